// File: rtl/linear_dequant_serializer.sv
// linear_dequant_serializer
//   Buffers whole 8-lane vectors from linear_dequant (which cannot be stalled)
//   in a DEPTH-entry FIFO. Each vector is replayed one lane per cycle as a
//   packed IEEE-754 single word on a valid/ready stream. A vector that arrives
//   while the FIFO is full is dropped, and the sticky overflow flag is set.
//
// Ports
//   clk, rstn            : clock, asynchronous active-low reset
//   enable               : input-side gate; src_valid is ignored while low
//   src_valid            : one vector present this cycle (must be taken)
//   src_man/exp/sign_0..7: lane fields of the incoming vector
//   dst_valid/dst_ready  : output word handshake
//   dst_data             : {sign, exp, man} of the current head lane
//   dst_lane, dst_last   : lane index of dst_data, high on lane 7
//   level                : vectors held, including a partially drained head
//   ovf_clr, overflow    : sticky drop flag and its synchronous clear
module linear_dequant_serializer #(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              enable,
  input  logic              src_valid,
  input  logic [22:0]       src_man_0,
  input  logic [22:0]       src_man_1,
  input  logic [22:0]       src_man_2,
  input  logic [22:0]       src_man_3,
  input  logic [22:0]       src_man_4,
  input  logic [22:0]       src_man_5,
  input  logic [22:0]       src_man_6,
  input  logic [22:0]       src_man_7,
  input  logic [7:0]        src_exp_0,
  input  logic [7:0]        src_exp_1,
  input  logic [7:0]        src_exp_2,
  input  logic [7:0]        src_exp_3,
  input  logic [7:0]        src_exp_4,
  input  logic [7:0]        src_exp_5,
  input  logic [7:0]        src_exp_6,
  input  logic [7:0]        src_exp_7,
  input  logic              src_sign_0,
  input  logic              src_sign_1,
  input  logic              src_sign_2,
  input  logic              src_sign_3,
  input  logic              src_sign_4,
  input  logic              src_sign_5,
  input  logic              src_sign_6,
  input  logic              src_sign_7,
  output logic              dst_valid,
  input  logic              dst_ready,
  output logic [31:0]       dst_data,
  output logic [2:0]        dst_lane,
  output logic              dst_last,
  output logic [LVL_W-1:0]  level,
  input  logic              ovf_clr,
  output logic              overflow
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [31:0]      src_word [8];
  logic [31:0]      fifo_mem [DEPTH][8];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q,  level_d;
  logic [2:0]       lane_q,   lane_d;
  logic             ovf_q,    ovf_d;

  logic push, hs, pop, full, accept, drop;

  always_comb begin
    src_word[0] = {src_sign_0, src_exp_0, src_man_0};
    src_word[1] = {src_sign_1, src_exp_1, src_man_1};
    src_word[2] = {src_sign_2, src_exp_2, src_man_2};
    src_word[3] = {src_sign_3, src_exp_3, src_man_3};
    src_word[4] = {src_sign_4, src_exp_4, src_man_4};
    src_word[5] = {src_sign_5, src_exp_5, src_man_5};
    src_word[6] = {src_sign_6, src_exp_6, src_man_6};
    src_word[7] = {src_sign_7, src_exp_7, src_man_7};
  end

  assign dst_valid = (level_q != '0);
  assign dst_data  = fifo_mem[rd_ptr_q][lane_q];
  assign dst_lane  = lane_q;
  assign dst_last  = (lane_q == 3'd7);
  assign level     = level_q;
  assign overflow  = ovf_q;

  always_comb begin
    push   = src_valid & enable;
    hs     = dst_valid & dst_ready;
    pop    = hs & (lane_q == 3'd7);
    full   = (level_q == LVL_W'(DEPTH));
    // A pop in the same cycle frees the head slot, so a full FIFO can still
    // accept; when full, wr_ptr equals rd_ptr and the write lands on the
    // slot being retired this cycle.
    accept = push & (~full | pop);
    drop   = push & full & ~pop;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    lane_d   = lane_q;
    ovf_d    = ovf_q;

    if (accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      lane_d   = 3'd0;
    end else if (hs) begin
      lane_d   = lane_q + 3'd1;
    end

    if (accept && !pop)      level_d = level_q + 1'b1;
    else if (pop && !accept) level_d = level_q - 1'b1;

    // Set has priority over clear so a drop in the clearing cycle is not lost.
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      lane_q   <= 3'd0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      lane_q   <= lane_d;
      ovf_q    <= ovf_d;
    end
  end

  // Vector storage carries no reset; entries are only read once level covers them.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < 8; i++) fifo_mem[wr_ptr_q][i] <= src_word[i];
    end
  end

endmodule

// File: tb/tb_linear_dequant_serializer.sv
// Directed bench for linear_dequant_serializer (DEPTH=4): a table of
// single-vector drain steps followed by hand-written multi-cycle sequences.
module tb_linear_dequant_serializer;

  localparam int DEPTH = 4;
  localparam int LVL_W = 3;

  logic clk = 1'b0;
  logic rstn, enable, src_valid, dst_ready, ovf_clr;
  logic dst_valid, dst_last, overflow;
  logic [31:0] dst_data;
  logic [2:0]  dst_lane;
  logic [LVL_W-1:0] level;
  logic [31:0] vw [8];

  int n_pass = 0;
  int n_total = 0;
  logic [31:0] expq [$];

  always #5 clk = ~clk;

  linear_dequant_serializer #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .src_valid(src_valid),
    .src_man_0(vw[0][22:0]), .src_man_1(vw[1][22:0]), .src_man_2(vw[2][22:0]),
    .src_man_3(vw[3][22:0]), .src_man_4(vw[4][22:0]), .src_man_5(vw[5][22:0]),
    .src_man_6(vw[6][22:0]), .src_man_7(vw[7][22:0]),
    .src_exp_0(vw[0][30:23]), .src_exp_1(vw[1][30:23]), .src_exp_2(vw[2][30:23]),
    .src_exp_3(vw[3][30:23]), .src_exp_4(vw[4][30:23]), .src_exp_5(vw[5][30:23]),
    .src_exp_6(vw[6][30:23]), .src_exp_7(vw[7][30:23]),
    .src_sign_0(vw[0][31]), .src_sign_1(vw[1][31]), .src_sign_2(vw[2][31]),
    .src_sign_3(vw[3][31]), .src_sign_4(vw[4][31]), .src_sign_5(vw[5][31]),
    .src_sign_6(vw[6][31]), .src_sign_7(vw[7][31]),
    .dst_valid(dst_valid), .dst_ready(dst_ready), .dst_data(dst_data),
    .dst_lane(dst_lane), .dst_last(dst_last), .level(level),
    .ovf_clr(ovf_clr), .overflow(overflow)
  );

  typedef struct {
    logic        push;
    logic        rdy;
    logic        ev;
    logic [31:0] ed;
    logic [2:0]  el;
    logic        elast;
    logic [2:0]  elvl;
  } row_t;

  row_t tbl [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input logic [31:0] base);
    for (int i = 0; i < 8; i++) vw[i] = base + 32'(i);
  endtask

  task automatic push_vec(input logic [31:0] base);
    set_vec(base);
    src_valid = 1'b1;
    step();
    src_valid = 1'b0;
  endtask

  // Drains every vector base queued in expq with ready held high, checking
  // each word in lane order, then checks the stream goes idle.
  task automatic drain_expect(input string tag);
    logic [31:0] b;
    dst_ready = 1'b1;
    while (expq.size() > 0) begin
      b = expq.pop_front();
      for (int l = 0; l < 8; l++) begin
        check({tag, "_valid"}, 32'(dst_valid), 32'd1);
        check({tag, "_data"}, dst_data, b + 32'(l));
        check({tag, "_lane"}, 32'(dst_lane), 32'(l));
        check({tag, "_last"}, 32'(dst_last), 32'(l == 7));
        step();
      end
    end
    check({tag, "_idle_valid"}, 32'(dst_valid), 32'd0);
    check({tag, "_idle_level"}, 32'(level), 32'd0);
  endtask

  initial begin
    // push, rdy, exp valid, exp data, exp lane, exp last, exp level
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h3F800000, 3'd0, 1'b0, 3'd1};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h3F800001, 3'd1, 1'b0, 3'd1};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 32'h3F800002, 3'd2, 1'b0, 3'd1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 32'h3F800003, 3'd3, 1'b0, 3'd1};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 32'h3F800004, 3'd4, 1'b0, 3'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 32'h3F800005, 3'd5, 1'b0, 3'd1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 32'h3F800006, 3'd6, 1'b0, 3'd1};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 32'h3F800007, 3'd7, 1'b1, 3'd1};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 32'h00000000, 3'd0, 1'b0, 3'd0};

    rstn = 1'b0; enable = 1'b1; src_valid = 1'b0; dst_ready = 1'b0; ovf_clr = 1'b0;
    set_vec(32'h0);
    step(); step();
    rstn = 1'b1;
    check("rst_valid", 32'(dst_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_lane", 32'(dst_lane), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Single vector through the table
    set_vec(32'h3F800000);
    for (int r = 0; r < 9; r++) begin
      src_valid = tbl[r].push;
      dst_ready = tbl[r].rdy;
      step();
      src_valid = 1'b0;
      check("tbl_valid", 32'(dst_valid), 32'(tbl[r].ev));
      check("tbl_lane", 32'(dst_lane), 32'(tbl[r].el));
      check("tbl_last", 32'(dst_last), 32'(tbl[r].elast));
      check("tbl_level", 32'(level), 32'(tbl[r].elvl));
      if (tbl[r].ev) check("tbl_data", dst_data, tbl[r].ed);
    end

    // Backpressure: ready pattern 1,0,0 repeating; word must hold until taken
    begin
      int n = 0;
      dst_ready = 1'b0;
      push_vec(32'h40000000);
      for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
        dst_ready = (cyc % 3 == 0);
        check("bp_valid", 32'(dst_valid), 32'd1);
        check("bp_data", dst_data, 32'h40000000 + 32'(n));
        check("bp_lane", 32'(dst_lane), 32'(n));
        if (dst_ready) n++;
        step();
      end
      dst_ready = 1'b0;
      check("bp_handshakes", 32'(n), 32'd8);
      check("bp_end_valid", 32'(dst_valid), 32'd0);
      check("bp_end_level", 32'(level), 32'd0);
    end

    // Overflow: 5 pushes into a 4-deep FIFO with no draining
    dst_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push_vec(32'h41000000 + 32'(k * 256));
    check("ovf_level", 32'(level), 32'd4);
    check("ovf_flag", 32'(overflow), 32'd1);
    for (int k = 1; k <= 4; k++) expq.push_back(32'h41000000 + 32'(k * 256));
    drain_expect("ovf_drain");
    check("ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_cleared", 32'(overflow), 32'd0);

    // Drop and clear in the same cycle: set wins
    dst_ready = 1'b0;
    for (int k = 1; k <= 4; k++) push_vec(32'h42000000 + 32'(k * 256));
    set_vec(32'h4200EE00);
    src_valid = 1'b1; ovf_clr = 1'b1;
    step();
    src_valid = 1'b0; ovf_clr = 1'b0;
    check("setwins_ovf", 32'(overflow), 32'd1);
    check("setwins_level", 32'(level), 32'd4);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("setwins_clr", 32'(overflow), 32'd0);

    // Full + pop collision: head at lane 7 handshakes while a new vector arrives
    dst_ready = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("coll_lane7", 32'(dst_lane), 32'd7);
    check("coll_pre_level", 32'(level), 32'd4);
    push_vec(32'h42000500);
    check("coll_level", 32'(level), 32'd4);
    check("coll_ovf", 32'(overflow), 32'd0);
    check("coll_lane0", 32'(dst_lane), 32'd0);
    for (int k = 2; k <= 5; k++) expq.push_back(32'h42000000 + 32'(k * 256));
    drain_expect("coll_drain");

    // Asynchronous reset mid-drain, with overflow set beforehand
    dst_ready = 1'b0;
    for (int k = 1; k <= 5; k++) push_vec(32'h43000000 + 32'(k * 256));
    dst_ready = 1'b1;
    for (int i = 0; i < 19; i++) step();
    dst_ready = 1'b0;
    check("mid_lane", 32'(dst_lane), 32'd3);
    check("mid_level", 32'(level), 32'd2);
    check("mid_ovf", 32'(overflow), 32'd1);
    #2 rstn = 1'b0;
    #1;
    check("arst_valid", 32'(dst_valid), 32'd0);
    check("arst_level", 32'(level), 32'd0);
    check("arst_ovf", 32'(overflow), 32'd0);
    step();
    rstn = 1'b1;
    step();
    push_vec(32'h44000000);
    expq.push_back(32'h44000000);
    drain_expect("post_rst");

    // Enable gating
    dst_ready = 1'b1;
    set_vec(32'h45000000);
    enable = 1'b0;
    src_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("gate_valid", 32'(dst_valid), 32'd0);
      check("gate_level", 32'(level), 32'd0);
    end
    enable = 1'b1;
    step();
    src_valid = 1'b0;
    expq.push_back(32'h45000000);
    drain_expect("gate_one");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/linear_dequant_serializer.md
Name: linear_dequant_serializer

Overview:
- Sits directly downstream of linear_dequant and consumes its 8-lane dst_* output vector.
- linear_dequant has no backpressure: one valid pulse means one vector that must be taken that cycle.
- This block buffers whole vectors in a small FIFO and serializes them one lane per cycle onto a valid/ready stream of packed IEEE-754 single-precision words.
- It flags any vector lost to overflow with a sticky error bit.

Parameters:
- DEPTH, 4, FIFO capacity in 8-lane vectors; power of two, minimum 2.
- LVL_W, log2(DEPTH)+1, width of the level output.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- enable  in  1  input-side gate; when low, src_valid is ignored.
- src_valid  in  1  vector strobe, connected to linear_dequant dst_valid.
- src_man_0 .. src_man_7  in  23 each  lane mantissas.
- src_exp_0 .. src_exp_7  in  8 each  lane exponents.
- src_sign_0 .. src_sign_7  in  1 each  lane signs.
- dst_valid  out  1  serialized word available.
- dst_ready  in  1  downstream accepts word.
- dst_data  out  32  {sign, exp[7:0], man[22:0]} of the current lane.
- dst_lane  out  3  index (0..7) of the lane presented on dst_data.
- dst_last  out  1  high when dst_lane==7.
- level  out  LVL_W  vectors held, including a partially drained head.
- ovf_clr  in  1  synchronous clear of overflow.
- overflow  out  1  sticky: a vector was dropped.

Behaviour:
- Reset (rstn low, any time, asynchronous): wr_ptr=0, rd_ptr=0, level=0, lane counter=0, overflow=0, dst_valid=0.
  - FIFO storage is not reset.
  - A partially drained vector is discarded.
- Write condition: push = src_valid & enable.
  - All 24 lane fields are captured into entry wr_ptr at the edge.
  - wr_ptr increments modulo DEPTH.
- Pop condition: pop = dst_valid & dst_ready & (lane==7).
  - rd_ptr increments modulo DEPTH; lane returns to 0.
- Handshake without pop (dst_valid & dst_ready & lane!=7): lane increments.
- Level update:
  - push only: +1.
  - pop only: -1.
  - push and pop together: level unchanged.
- Full case: push while level==DEPTH and no pop in the same cycle.
  - The vector is dropped; pointers and level are unchanged.
  - overflow is set at that edge.
- Full with simultaneous pop: the push is accepted and no overflow occurs; the freed slot is reused that cycle.
- Empty case: dst_valid=0 and lane held at 0.
  - A push into an empty FIFO makes dst_valid=1 in the next cycle, with lane 0 of the new vector.
  - No same-cycle bypass; minimum latency is 1 cycle from src_valid to dst_valid.
- Output timing: dst_valid = (level!=0).
  - dst_data, dst_lane and dst_last are driven from registered state: head entry rd_ptr and the lane counter.
- Stability: while dst_valid=1 and dst_ready=0, dst_data, dst_lane and dst_last hold stable, and dst_valid does not fall.
- Throughput: sustained 1 word/cycle with dst_ready held high, i.e. one vector per 8 cycles.
  - Input faster than that fills the FIFO, then drops.
- dst_data packing per lane i: {src_sign_i, src_exp_i, src_man_i}.
  - Bits pass through unmodified; no NaN/denormal handling.
- overflow stays set until ovf_clr=1 at an edge.
  - If a drop and ovf_clr occur in the same cycle, set wins and overflow stays 1.
- enable low: no pushes. Draining continues normally; the output side does not use enable.

Test Plan:
- Single vector: reset, push one vector with lanes = 0x3F800000 + i, dst_ready=1.
  - Required: dst_valid high in cycles 1..8 after push.
  - dst_data 0x3F800000..0x3F800007 with dst_lane 0..7.
  - dst_last only on the 8th word; level 1→0 after the 8th handshake.
- Backpressure: same vector, dst_ready toggling 1,0,0,1,...
  - Required: each word held stable while ready=0.
  - Exactly 8 handshakes total, in lane order, with no duplicates or skips.
- Overflow: DEPTH=4, dst_ready=0, push 5 vectors.
  - Required: level=4 and overflow=1 after the 5th push.
  - Draining yields vectors 1–4 only; ovf_clr pulse then returns overflow to 0.
- Full + pop collision: level=4, head at lane 7 with dst_ready=1, push in the same cycle.
  - Required: level stays 4, overflow stays 0, and the new vector appears last in drain order.
- Reset mid-drain: assert rstn=0 asynchronously while the head is at lane 3 with level=2.
  - Required: immediately dst_valid=0, level=0, overflow=0.
  - After release, a fresh push is drained starting at lane 0.
- Enable gating: enable=0 while src_valid=1 for 3 cycles.
  - Required: level unchanged and no words emitted.
  - enable=1 with src_valid=1 for 1 cycle → exactly one vector emitted.
